// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared definitions for the data-memory responder.
//               Provides the access-size encodings, the responder state
//               encoding, the latched-request record and a helper that maps
//               an access size onto a byte count.
// Revision    : 1.0  initial release
// ============================================================================
package dmem_pkg;

  // Access sizes carried on req_size; encoding 2'd3 is illegal.
  localparam logic [1:0] MEM_BYTE = 2'd0;
  localparam logic [1:0] MEM_HALF = 2'd1;
  localparam logic [1:0] MEM_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // A request as captured at the accept edge.
  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        is_unsigned;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dmem_req_t;

  // Number of bytes touched by an access. The illegal size reports 4 so the
  // range check stays conservative; the request is rejected anyway.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      MEM_BYTE: return 3'd1;
      MEM_HALF: return 3'd2;
      default:  return 3'd4;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_load_extend.sv
`default_nettype none
// ============================================================================
// Module      : dmem_load_extend
// Description : Combinational load-data formatter. Takes the four bytes read
//               little-endian from the array and sign- or zero-extends them
//               according to the access size.
// Ports       : b0..b3      in  8   bytes at addr+0 .. addr+3
//               size        in  2   MEM_BYTE / MEM_HALF / MEM_WORD
//               is_unsigned in  1   1 = zero-extend, 0 = sign-extend
//               ext_data    out 32  extended load value
// Revision    : 1.0  initial release
// ============================================================================
module dmem_load_extend
  import dmem_pkg::*;
(
  input  logic [7:0]  b0,
  input  logic [7:0]  b1,
  input  logic [7:0]  b2,
  input  logic [7:0]  b3,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] ext_data
);

  logic fill_byte;
  logic fill_half;

  // Fill bit is the sign bit for signed loads, zero otherwise.
  assign fill_byte = ~is_unsigned & b0[7];
  assign fill_half = ~is_unsigned & b1[7];

  always_comb begin
    ext_data = {b3, b2, b1, b0};
    case (size)
      MEM_BYTE: ext_data = {{24{fill_byte}}, b0};
      MEM_HALF: ext_data = {{16{fill_half}}, b1, b0};
      default:  ext_data = {b3, b2, b1, b0};
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Target end of the core load/store interface. Accepts one
//               byte/half/word request at a time, waits WAIT_CYCLES, performs
//               the access on a little-endian byte array and returns the
//               extended load data or a store acknowledgement.
// Ports       : clk, rst (async, active-high)
//               req_valid/req_ready, req_we, req_size, req_unsigned,
//               req_addr, req_wdata                 request channel
//               rsp_valid/rsp_ready, rsp_rdata, rsp_err   response channel
// Revision    : 1.0  initial release
// ============================================================================
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_BYTES = 4096,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          AW        = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);
  localparam bit          NO_WAIT   = (WAIT_CYCLES == 0);
  localparam logic [32:0] DEPTH_LIM = 33'(DEPTH_BYTES);

  logic [7:0] mem [DEPTH_BYTES];

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  dmem_req_t   req_q, req_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  dmem_req_t   req_in;
  dmem_req_t   acc;
  logic [32:0] last_addr;
  logic        acc_err;
  logic [3:0]  lane_en;
  logic [AW-1:0] idx [4];
  logic [7:0]  rd_byte [4];
  logic [31:0] ext_data;
  logic [31:0] acc_rdata;
  logic        do_access;
  logic        mem_we;

  assign req_ready = (state_q == ST_IDLE) && !rst;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  assign req_in = '{we: req_we, size: req_size, is_unsigned: req_unsigned,
                    addr: req_addr, wdata: req_wdata};

  // Without wait states the access happens on the accept edge, so it must
  // use the live request rather than the (not yet loaded) latched copy.
  assign acc = (NO_WAIT && state_q == ST_IDLE) ? req_in : req_q;

  // Range check in 33 bits so addresses near 2^32 cannot wrap into range.
  always_comb begin
    last_addr = {1'b0, acc.addr} + 33'(size_bytes(acc.size)) - 33'd1;
    acc_err   = (acc.size == 2'd3)
             || (acc.size == MEM_HALF && acc.addr[0])
             || (acc.size == MEM_WORD && acc.addr[1:0] != 2'b00)
             || (last_addr >= DEPTH_LIM);
    lane_en = 4'b0000;
    if (!acc_err) begin
      case (acc.size)
        MEM_BYTE: lane_en = 4'b0001;
        MEM_HALF: lane_en = 4'b0011;
        default:  lane_en = 4'b1111;
      endcase
    end
  end

  // Disabled lanes are forced to index 0 so a rejected or short request
  // never forms an out-of-range array index.
  for (genvar k = 0; k < 4; k++) begin : g_lane
    assign idx[k]     = lane_en[k] ? (acc.addr[AW-1:0] + AW'(k)) : '0;
    assign rd_byte[k] = (lane_en[k] && !acc.we) ? mem[idx[k]] : 8'h00;
  end

  dmem_load_extend u_extend (
    .b0          (rd_byte[0]),
    .b1          (rd_byte[1]),
    .b2          (rd_byte[2]),
    .b3          (rd_byte[3]),
    .size        (acc.size),
    .is_unsigned (acc.is_unsigned),
    .ext_data    (ext_data)
  );

  assign acc_rdata = (acc_err || acc.we) ? 32'h0 : ext_data;

  assign do_access = (NO_WAIT && state_q == ST_IDLE && req_valid)
                  || (state_q == ST_BUSY && cnt_q == 4'd1);
  // Reset must also block a zero-wait store presented while rst is high.
  assign mem_we    = do_access && acc.we && !rst;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int k = 0; k < 4; k++) begin
        if (lane_en[k]) mem[idx[k]] <= acc.wdata[8*k +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          req_d = req_in;
          cnt_d = WAIT_INIT;
          if (NO_WAIT) begin
            state_d = ST_RESP;
            rdata_d = acc_rdata;
            err_d   = acc_err;
          end else begin
            state_d = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = ST_RESP;
          rdata_d = acc_rdata;
          err_d   = acc_err;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
          rdata_d = 32'h0;
          err_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      req_q   <= '0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Directed self-checking bench for dmem_responder. Two
//               instances (WAIT_CYCLES = 2 and 0) share the stimulus; sel
//               routes the handshakes to one of them. Expected responses are
//               queued when a request is issued and popped when it returns.
//               Latency is counted with the accept edge as edge 1.
// Revision    : 1.0  initial release
// ============================================================================
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        req_valid, req_we, req_unsigned, rsp_ready;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;

  logic        rr2, rv2, re2, rr0, rv0, re0;
  logic [31:0] rd2, rd0;

  logic        req_ready_s, rsp_valid_s, rsp_err_s;
  logic [31:0] rsp_rdata_s;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb [$];
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_BYTES(4096), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid & ~sel), .req_ready(rr2),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv2), .rsp_ready(rsp_ready & ~sel),
    .rsp_rdata(rd2), .rsp_err(re2)
  );

  dmem_responder #(.DEPTH_BYTES(4096), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid & sel), .req_ready(rr0),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv0), .rsp_ready(rsp_ready & sel),
    .rsp_rdata(rd0), .rsp_err(re0)
  );

  assign req_ready_s = sel ? rr0 : rr2;
  assign rsp_valid_s = sel ? rv0 : rv2;
  assign rsp_rdata_s = sel ? rd0 : rd2;
  assign rsp_err_s   = sel ? re0 : re2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request, measure latency, check the response, optionally hold
  // the response under back-pressure for 'hold' cycles, then complete it.
  task automatic xact(input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_d, input logic exp_e, input int hold);
    exp_t e;
    int   lat;
    e.rdata = exp_d;
    e.err   = exp_e;
    sb.push_back(e);

    @(negedge clk);
    chk("req_ready_idle", {31'b0, req_ready_s}, 32'd1);
    req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    @(posedge clk); #1;
    // Scramble inputs after acceptance; they must have no effect.
    req_valid = 1'b0; req_we = ~we; req_size = 2'($urandom);
    req_unsigned = ~uns; req_addr = $urandom; req_wdata = $urandom;

    lat = 1;
    while (!rsp_valid_s && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 32'(lat), sel ? 32'd1 : 32'd3);

    if (sb.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk("rsp_rdata", rsp_rdata_s, e.rdata);
      chk("rsp_err", {31'b0, rsp_err_s}, {31'b0, e.err});
    end

    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      rsp_ready = 1'b0;
      req_valid = ~req_valid;
      @(posedge clk); #1;
      chk("hold_valid", {31'b0, rsp_valid_s}, 32'd1);
      chk("hold_rdata", rsp_rdata_s, e.rdata);
      chk("hold_ready", {31'b0, req_ready_s}, 32'd0);
    end

    @(negedge clk);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("post_valid", {31'b0, rsp_valid_s}, 32'd0);
    chk("post_rdata", rsp_rdata_s, 32'd0);
    chk("post_err", {31'b0, rsp_err_s}, 32'd0);
    chk("post_ready", {31'b0, req_ready_s}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; sel = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b0;

    // Reset state
    #1;
    chk("rst_req_ready", {31'b0, req_ready_s}, 32'd0);
    chk("rst_rsp_valid", {31'b0, rsp_valid_s}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata_s, 32'd0);
    chk("rst_rsp_err", {31'b0, rsp_err_s}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("idle_req_ready", {31'b0, req_ready_s}, 32'd1);

    // Word store/load and sub-word loads
    xact(1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 0);
    xact(0, 2'd2, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 0);
    xact(0, 2'd0, 0, 32'h13, 32'h0, 32'hFFFFFFDE, 0, 0);
    xact(0, 2'd0, 1, 32'h13, 32'h0, 32'h000000DE, 0, 0);
    xact(0, 2'd1, 0, 32'h10, 32'h0, 32'hFFFFBEEF, 0, 0);

    // Partial stores keep neighbouring bytes
    xact(1, 2'd2, 0, 32'h20, 32'hCAFEF00D, 32'h0, 0, 0);
    xact(1, 2'd1, 0, 32'h20, 32'h00001234, 32'h0, 0, 0);
    xact(0, 2'd2, 0, 32'h20, 32'h0, 32'hCAFE1234, 0, 0);
    xact(1, 2'd0, 0, 32'h21, 32'h000000AB, 32'h0, 0, 0);
    xact(0, 2'd1, 0, 32'h20, 32'h0, 32'hFFFFAB34, 0, 0);

    // Rejected requests leave memory untouched
    xact(1, 2'd1, 0, 32'hFFE, 32'h00005A5A, 32'h0, 0, 0);
    xact(1, 2'd1, 0, 32'h11, 32'h0000FFFF, 32'h0, 1, 0);
    xact(1, 2'd2, 0, 32'h12, 32'h00000000, 32'h0, 1, 0);
    xact(1, 2'd2, 0, 32'hFFE, 32'h11223344, 32'h0, 1, 0);
    xact(1, 2'd3, 0, 32'h10, 32'h00000000, 32'h0, 1, 0);
    xact(0, 2'd3, 0, 32'h10, 32'h0, 32'h0, 1, 0);
    xact(0, 2'd2, 0, 32'hFFFFFFFC, 32'h0, 32'h0, 1, 0);
    xact(0, 2'd2, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 0);
    xact(0, 2'd1, 1, 32'hFFE, 32'h0, 32'h00005A5A, 0, 0);
    xact(0, 2'd0, 0, 32'hFFF, 32'h0, 32'h0000005A, 0, 0);

    // Back-pressure
    xact(0, 2'd2, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 5);

    // Reset during BUSY discards a pending store
    xact(1, 2'd0, 0, 32'h30, 32'h00000077, 32'h0, 0, 0);
    @(negedge clk);
    req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h30; req_wdata = 32'h00000055; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("busy_rsp_valid", {31'b0, rsp_valid_s}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_busy_ready", {31'b0, req_ready_s}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("aborted_rsp_valid", {31'b0, rsp_valid_s}, 32'd0);
    end
    xact(0, 2'd0, 1, 32'h30, 32'h0, 32'h00000077, 0, 0);

    // Zero wait states
    sel = 1'b1;
    xact(1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 0);
    xact(0, 2'd2, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 0);
    xact(0, 2'd0, 0, 32'h12, 32'h0, 32'hFFFFFFAD, 0, 0);
    xact(1, 2'd2, 0, 32'hFFE, 32'h11223344, 32'h0, 1, 2);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
